// File: rtl/conv_pkg.sv
// Shared configuration and state type for the conv1 frame sequencer.
package conv_pkg;

  localparam int IMG_W            = 32;
  localparam int IMG_H            = 32;
  localparam int KERNEL           = 5;
  localparam int MAC_LATENCY      = 4;
  localparam int NUM_CONV_FILTERS = 6;
  localparam int OUT_PER_FRAME    = (IMG_H - KERNEL + 1) * (IMG_W - KERNEL + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} seq_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-latency valid pipe that mirrors the MAC pipeline; it never stalls.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_valid,
  output logic o_empty
);

  logic [DEPTH-1:0] r_shift;
  logic [DEPTH-1:0] w_behind;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
    end else begin
      r_shift <= (r_shift << 1) | DEPTH'(i_valid);
    end
  end

  assign o_valid = r_shift[DEPTH-1];

  // Empty means nothing is queued behind the tail, so the line drains this cycle.
  assign w_behind = r_shift << 1;
  assign o_empty  = (w_behind == '0);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller for conv1: pops pixels, tracks window position and results in flight.
module conv_frame_sequencer #(
  parameter int IMG_W       = conv_pkg::IMG_W,
  parameter int IMG_H       = conv_pkg::IMG_H,
  parameter int KERNEL      = conv_pkg::KERNEL,
  parameter int MAC_LATENCY = conv_pkg::MAC_LATENCY
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_feature_valid,
  output logic                     o_rd_en,
  output logic                     o_shift_en,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic [$clog2(IMG_W)-1:0] o_col,
  output logic                     o_window_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_valid,
  output logic                     o_last_feature,
  output logic                     o_busy,
  output logic                     o_done
);

  import conv_pkg::*;

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int N_OUT = (IMG_H - KERNEL + 1) * (IMG_W - KERNEL + 1);
  localparam int CNT_W = $clog2(N_OUT);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [CNT_W-1:0] r_out_cnt;
  logic             w_accept;
  logic             w_start;
  logic             w_col_wrap;
  logic             w_last_pixel;
  logic             w_window;
  logic             w_out_valid;
  logic             w_dl_empty;

  assign w_start      = (r_state == IDLE) & i_start;
  assign w_col_wrap   = (r_col == COL_W'(IMG_W - 1));
  assign w_last_pixel = w_col_wrap & (r_row == ROW_W'(IMG_H - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = RUN;
      RUN:     if (w_accept && w_last_pixel) w_state_next = FLUSH;
      FLUSH:   if (w_dl_empty) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (r_state)
      RUN: begin
        w_accept = i_feature_valid & i_out_ready;
        o_busy   = 1'b1;
      end
      FLUSH:   o_busy = 1'b1;
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Position of the pixel at the FWFT head; advances only when it is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign w_window = w_accept & (r_row >= ROW_W'(KERNEL - 1)) & (r_col >= COL_W'(KERNEL - 1));

  valid_delay_line #(
    .DEPTH (MAC_LATENCY)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (w_window),
    .o_valid (w_out_valid),
    .o_empty (w_dl_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_cnt <= '0;
    end else if (w_start) begin
      r_out_cnt <= '0;
    end else if (w_out_valid) begin
      r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  assign o_rd_en        = w_accept;
  assign o_shift_en     = w_accept;
  assign o_row          = r_row;
  assign o_col          = r_col;
  assign o_window_valid = w_window;
  assign o_out_valid    = w_out_valid;
  assign o_last_feature = w_out_valid & (r_out_cnt == CNT_W'(N_OUT - 1));

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench: cycle model built from pixel indices and result due-times.
module tb_conv_frame_sequencer;
  import conv_pkg::*;

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int BUDGET = 8000;

  logic                     i_clk;
  logic                     i_rst_n;
  logic                     i_start;
  logic                     i_feature_valid;
  logic                     i_out_ready;
  logic                     o_rd_en;
  logic                     o_shift_en;
  logic [$clog2(IMG_H)-1:0] o_row;
  logic [$clog2(IMG_W)-1:0] o_col;
  logic                     o_window_valid;
  logic                     o_out_valid;
  logic                     o_last_feature;
  logic                     o_busy;
  logic                     o_done;

  conv_frame_sequencer dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_feature_valid (i_feature_valid),
    .o_rd_en         (o_rd_en),
    .o_shift_en      (o_shift_en),
    .o_row           (o_row),
    .o_col           (o_col),
    .o_window_valid  (o_window_valid),
    .i_out_ready     (i_out_ready),
    .o_out_valid     (o_out_valid),
    .o_last_feature  (o_last_feature),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: frame active flag, pixels taken, results emitted, due cycles.
  bit m_active   = 0;
  int m_pops     = 0;
  int m_outs     = 0;
  int m_done_cyc = -1;
  int m_due[$];

  // Observations of the DUT for end-of-frame checks.
  int obs_pops, obs_outs, obs_last_cnt;
  int obs_first_win_pop, obs_first_win_cyc, obs_first_out_cyc;
  int obs_last_cyc, obs_done_cyc, obs_first_row, obs_first_col;
  int obs_win_row [IMG_H];

  typedef struct {
    logic st, fv, rdy;
    logic e_rd, e_busy;
    int   e_row, e_col;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic reset_obs();
    obs_pops = 0; obs_outs = 0; obs_last_cnt = 0;
    obs_first_win_pop = -1; obs_first_win_cyc = -1; obs_first_out_cyc = -1;
    obs_last_cyc = -1; obs_done_cyc = -1; obs_first_row = -1; obs_first_col = -1;
    for (int r = 0; r < IMG_H; r++) obs_win_row[r] = 0;
  endtask

  task automatic step(input logic st, input logic fv, input logic rdy);
    bit e_rd, e_win, e_out, e_last, e_done;
    int e_row, e_col;
    @(negedge i_clk);
    i_start = st; i_feature_valid = fv; i_out_ready = rdy;
    #2;
    e_rd   = m_active && (m_pops < NPIX) && fv && rdy;
    e_row  = (m_pops % NPIX) / IMG_W;
    e_col  = m_pops % IMG_W;
    e_win  = e_rd && (e_row >= KERNEL - 1) && (e_col >= KERNEL - 1);
    e_out  = (m_due.size() > 0) && (m_due[0] == cyc);
    e_last = e_out && (m_outs == OUT_PER_FRAME - 1);
    e_done = m_active && (cyc == m_done_cyc);
    chk("rd_en", int'(o_rd_en), int'(e_rd));
    chk("shift_en", int'(o_shift_en), int'(e_rd));
    chk("row", int'(o_row), e_row);
    chk("col", int'(o_col), e_col);
    chk("window_valid", int'(o_window_valid), int'(e_win));
    chk("out_valid", int'(o_out_valid), int'(e_out));
    chk("last_feature", int'(o_last_feature), int'(e_last));
    chk("busy", int'(o_busy), int'(m_active));
    chk("done", int'(o_done), int'(e_done));
    if (o_rd_en) begin
      if (obs_pops == 0) begin obs_first_row = o_row; obs_first_col = o_col; end
      obs_pops++;
    end
    if (o_window_valid) begin
      obs_win_row[o_row]++;
      if (obs_first_win_pop < 0) begin obs_first_win_pop = obs_pops; obs_first_win_cyc = cyc; end
    end
    if (o_out_valid) begin
      if (obs_outs == 0) obs_first_out_cyc = cyc;
      obs_outs++;
    end
    if (o_last_feature) begin obs_last_cnt++; obs_last_cyc = cyc; end
    if (o_done) obs_done_cyc = cyc;
    if (e_rd) m_pops++;
    if (e_win) m_due.push_back(cyc + MAC_LATENCY);
    if (e_out) begin void'(m_due.pop_front()); m_outs++; end
    if (e_last) m_done_cyc = cyc + 1;
    if (e_done) m_active = 0;
    else if (!m_active && st) begin
      m_active = 1; m_pops = 0; m_outs = 0; m_done_cyc = -1; m_due.delete();
    end
    cyc++;
  endtask

  task automatic do_reset(input bit mid);
    @(negedge i_clk);
    i_start = 0; i_feature_valid = mid; i_out_ready = 1;
    #2;
    if (mid) chk("pop500_rd_en", int'(o_rd_en), 1);
    i_rst_n = 0;
    #1;
    chk("rst_outputs", int'({o_rd_en, o_shift_en, o_row, o_col, o_window_valid,
                             o_out_valid, o_last_feature, o_busy, o_done}), 0);
    chk("rst_busy", int'(o_busy), 0);
    m_active = 0; m_pops = 0; m_outs = 0; m_done_cyc = -1; m_due.delete();
    @(negedge i_clk);
    i_rst_n = 1;
    cyc++;
  endtask

  task automatic frame_checks();
    int early, bad;
    early = 0; bad = 0;
    chk("frame_pops", obs_pops, NPIX);
    chk("frame_outs", obs_outs, OUT_PER_FRAME);
    chk("first_window_pop", obs_first_win_pop, (KERNEL - 1) * IMG_W + KERNEL);
    chk("first_out_lag", obs_first_out_cyc - obs_first_win_cyc, MAC_LATENCY);
    chk("last_feature_count", obs_last_cnt, 1);
    chk("done_after_last", obs_done_cyc - obs_last_cyc, 1);
    chk("first_pop_pos", obs_first_row * IMG_W + obs_first_col, 0);
    for (int r = 0; r < IMG_H; r++) begin
      if (r < KERNEL - 1) early += obs_win_row[r];
      else if (obs_win_row[r] != IMG_W - KERNEL + 1) bad++;
    end
    chk("edge_windows", early, 0);
    chk("rows_wrong_window_count", bad, 0);
  endtask

  task automatic run_frame(input bit do_start, input int fv_pct, input int rdy_pct,
                           input bit noise, input int stall_at, input int rst_at);
    bit stalled;
    bit st;
    int p0, o0, n;
    stalled = 0; n = 0;
    if (do_start) begin
      reset_obs();
      step(1, 1'($urandom_range(99) < fv_pct), 1'($urandom_range(99) < rdy_pct));
    end
    while (obs_done_cyc < 0 && n < BUDGET) begin
      if (rst_at >= 0 && m_active && obs_pops == rst_at - 1) begin
        do_reset(1);
        return;
      end
      if (stall_at >= 0 && !stalled && obs_pops == stall_at) begin
        stalled = 1; p0 = obs_pops; o0 = obs_outs;
        repeat (10) step(0, 1, 0);
        chk("stall_pops", obs_pops - p0, 0);
        chk("stall_outs_le_latency", int'((obs_outs - o0) <= MAC_LATENCY), 1);
      end
      st = noise && ($urandom_range(5) == 0);
      if (noise && cyc == m_done_cyc) st = 1;
      step(st, 1'($urandom_range(99) < fv_pct), 1'($urandom_range(99) < rdy_pct));
      n++;
    end
    if (obs_done_cyc < 0) chk("frame_timeout", 0, 1);
    else frame_checks();
  endtask

  initial begin
    i_rst_n = 0; i_start = 0; i_feature_valid = 0; i_out_ready = 0;
    tbl[0] = '{st:1, fv:1, rdy:1, e_rd:0, e_busy:0, e_row:0, e_col:0};
    tbl[1] = '{st:0, fv:0, rdy:1, e_rd:0, e_busy:1, e_row:0, e_col:0};
    tbl[2] = '{st:0, fv:1, rdy:0, e_rd:0, e_busy:1, e_row:0, e_col:0};
    tbl[3] = '{st:0, fv:1, rdy:1, e_rd:1, e_busy:1, e_row:0, e_col:0};
    tbl[4] = '{st:1, fv:1, rdy:1, e_rd:1, e_busy:1, e_row:0, e_col:1};
    tbl[5] = '{st:0, fv:0, rdy:1, e_rd:0, e_busy:1, e_row:0, e_col:2};
    tbl[6] = '{st:0, fv:1, rdy:1, e_rd:1, e_busy:1, e_row:0, e_col:2};

    do_reset(0);

    // Frame 1: hand table for the opening cycles, then FWFT always valid.
    reset_obs();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].st, tbl[i].fv, tbl[i].rdy);
      chk("tbl_rd_en", int'(o_rd_en), int'(tbl[i].e_rd));
      chk("tbl_busy", int'(o_busy), int'(tbl[i].e_busy));
      chk("tbl_row", int'(o_row), tbl[i].e_row);
      chk("tbl_col", int'(o_col), tbl[i].e_col);
    end
    run_frame(0, 100, 100, 0, -1, -1);

    run_frame(1, 50, 100, 0, -1, -1);
    run_frame(1, 100, 100, 0, 10 * IMG_W + 7, -1);
    run_frame(1, 80, 100, 1, -1, -1);
    run_frame(1, 100, 100, 0, -1, -1);
    run_frame(1, 100, 100, 0, -1, 500);
    step(0, 1, 1);
    run_frame(1, 60, 85, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
